// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, shared tick prescaler, per-channel stability filter, press/release pulses.
// Optional long-press detection is built when BUTTON_DEBOUNCE_LONGPRESS_EN is defined.
module button_debounce #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter bit RESET_LEVEL  = 1'b1,
  parameter int LONG_TICKS   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_db,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_LEVEL}};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_s;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic [WIDTH-1:0] long_q, long_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RST_VEC;
      sync2_q <= RST_VEC;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign tick_s = (presc_q == TICK_LAST);

  always_comb begin
    presc_d = presc_q;
    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1'b1);
    end
  end

  // Any sample that agrees with the accepted level restarts qualification.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (tick_s && (cnt_q[i] == CNT_LAST)) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = {CW{1'b0}};
      end else if (tick_s) begin
        cnt_d[i] = cnt_q[i] + CW'(1'b1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    press_d = db_q & ~db_d;
    rel_d   = ~db_q & db_d;
  end

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam int LW = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS);

  logic [LW-1:0] hold_q [WIDTH];
  logic [LW-1:0] hold_d [WIDTH];

  // Hold counter saturates at LONG_TICKS so each press yields one pulse.
  always_comb begin
    long_d = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      hold_d[i] = hold_q[i];
      if (db_q[i]) begin
        hold_d[i] = {LW{1'b0}};
      end else if (tick_s && (hold_q[i] != LONG_LAST)) begin
        hold_d[i] = hold_q[i] + LW'(1'b1);
        long_d[i] = (hold_q[i] == LONG_LAST - LW'(1'b1));
      end else begin
        hold_d[i] = hold_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= {LW{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  always_comb begin
    long_d = {WIDTH{1'b0}};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= {PW{1'b0}};
      db_q    <= RST_VEC;
      press_q <= {WIDTH{1'b0}};
      rel_q   <= {WIDTH{1'b0}};
      long_q  <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= {CW{1'b0}};
    end else begin
      presc_q <= presc_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_db        = db_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;

endmodule

// File: doc/button_debounce.md
# button_debounce

Per-channel push-button conditioner upstream of the button PIO on the DE2 board. Synchronises raw, bouncing KEY inputs to `clk`, filters each channel with a tick-based stability counter, and drives the clean level into the PIO `in_port`. Also emits one-cycle press and release pulses for local logic, and optionally long-press pulses. Polarity is preserved (keys are active-low), so the PIO's falling-edge capture sees exactly one edge per physical press.

## Interface
- `WIDTH`, 4: number of button channels.
- `TICK_DIV`, 50000: `clk` cycles per sample tick (1 ms at 50 MHz); must be ≥1.
- `STABLE_TICKS`, 10: consecutive mismatching ticks required to accept a new level; must be ≥1.
- `RESET_LEVEL`, 1: level loaded into every channel's synchroniser and debounced state at reset (1 = released).
- `LONG_TICKS`, 1000: ticks a channel must stay pressed before `long_press` fires (used only with the macro).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `key_in` in WIDTH: raw asynchronous button pins, active-low.
- `key_db` out WIDTH: debounced level, feeds PIO `in_port`.
- `press_pulse` out WIDTH: one-cycle pulse on debounced 1→0.
- `release_pulse` out WIDTH: one-cycle pulse on debounced 0→1.
- `long_press` out WIDTH: one-cycle long-press pulse; constant 0 without the macro.

## Operation
- **Synchroniser:** two flops per channel. `s` is the output of the second flop.
- **Prescaler:** a shared counter runs 0..TICK_DIV-1 and then wraps to 0.
  - `tick` = (count == TICK_DIV-1).
  - With TICK_DIV=1, `tick` is high every cycle.
- **Per-channel filter:** a counter `cnt` of width clog2(STABLE_TICKS)+1. Every cycle:
  - if `s == key_db[i]`: `cnt` ← 0 (any bounce back restarts filtering);
  - else if `tick` and `cnt == STABLE_TICKS-1`: `key_db[i]` ← `s` and `cnt` ← 0;
  - else if `tick`: `cnt` ← `cnt`+1;
  - otherwise hold.
- **Pulses:**
  - `press_pulse[i]` is registered high for exactly the cycle in which `key_db[i]` first shows 0 after being 1.
  - `release_pulse[i]` is the symmetric case for 0→1.
  - The two pulses are never high simultaneously on one channel.
- **Channel independence:** channels are fully independent. Simultaneous transitions on several channels are all accepted on the same tick.
- **No saturation issue:** `cnt` never exceeds STABLE_TICKS-1.

## Timing
- **Reset values:**
  - sync flops and `key_db` = {WIDTH{RESET_LEVEL}};
  - all counters, including the prescaler, = 0;
  - `press_pulse`, `release_pulse`, `long_press` = 0.
- **Reset mid-filter:** discards partial counts. After reset release, a held key is re-qualified from scratch.
- **Latency:** from a clean raw change to the `key_db` change:
  - minimum 2 + (STABLE_TICKS-1)·TICK_DIV + 1 cycles;
  - maximum 2 + STABLE_TICKS·TICK_DIV cycles.
- **Pulse alignment:** pulses coincide with the `key_db` edge; there is no added latency.
- **Glitch rejection:** a raw glitch shorter than (STABLE_TICKS-1)·TICK_DIV cycles never changes `key_db`.
- **Outputs:** all outputs are registered. No combinational path from `key_in`.

## Configuration
- **`BUTTON_DEBOUNCE_LONGPRESS_EN` defined:** adds a per-channel hold counter.
  - Counting: the counter is cleared while `key_db[i]`=1 and increments on each `tick` while `key_db[i]`=0.
  - Firing: when the count reaches LONG_TICKS, `long_press[i]` pulses for one cycle; the counter then saturates, so there is one pulse per press.
  - Re-arm: release clears the counter and re-arms the pulse.
- **Macro undefined:** no hold counters are built and `long_press` is tied to 0.

## Test plan
- **Reset:** assert `reset` mid-run with `key_in` = 4'b0000 held → all `key_db` = 4'b1111 immediately, pulses 0.
  - After release, `key_db` stays 4'b1111 until requalified.
- **Clean press** (TICK_DIV=4, STABLE_TICKS=3): drive `key_in[0]` 1→0 and hold.
  - `key_db[0]` falls between 11 and 14 cycles later.
  - `press_pulse[0]` is high for exactly 1 cycle, aligned with the fall.
  - Other bits remain 1.
- **Bounce** (same parameters): toggle `key_in[1]` low/high every 3 cycles for 40 cycles, then hold low.
  - No `key_db[1]` change during bouncing.
  - Exactly one fall and one `press_pulse[1]`, within 14 cycles of the final transition.
- **Simultaneous:** release `key_in[3:2]` together after a stable press.
  - `key_db[3:2]` rise in the same cycle.
  - `release_pulse` = 4'b1100 for one cycle.
- **Tick boundary** (TICK_DIV=1, STABLE_TICKS=1): a 2-cycle low glitch on `key_in[2]` → `key_db[2]` follows it.
  - Confirms the degenerate configuration passes levels through after the 2-cycle synchroniser plus 1 cycle.
- **Long press** (macro on, LONG_TICKS=5, TICK_DIV=4, STABLE_TICKS=3): hold `key_in[0]` low 60 cycles.
  - One `long_press[0]` pulse, 20–24 cycles after the `key_db[0]` fall; none repeat.
  - With the macro off, `long_press` stays 0.
